// File: rtl/riscv_top_pkg.sv
// Shared SDRAM command encodings, bus widths and the init/refresh FSM state type
// for the riscv_top bring-up shell.
package riscv_top_pkg;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 13;

    // Command word is {nCS, nRAS, nCAS, nWE}
    localparam logic [CMD_W-1:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_REFRESH   = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_LOAD_MODE = 4'b0000;

    localparam logic [ADDR_W-1:0] ADDR_PRECHARGE_ALL = 13'h0400;

    typedef enum logic [3:0] {
        ST_WAIT,
        ST_PRE,
        ST_PRE_WAIT,
        ST_REF1,
        ST_REF1_WAIT,
        ST_REF2,
        ST_REF2_WAIT,
        ST_MRS,
        ST_MRS_WAIT,
        ST_IDLE,
        ST_AREF,
        ST_AREF_WAIT
    } sdram_state_e;

endpackage

// File: rtl/riscv_top_sdram_init.sv
// SDRAM power-up sequence (NOP wait, precharge-all, two refreshes, mode load)
// followed by periodic auto-refresh. Command, address and ready are registered.
module riscv_top_sdram_init
    import riscv_top_pkg::*;
#(
    parameter int                INIT_CYCLES      = 10000,
    parameter int                T_RP             = 3,
    parameter int                T_RFC            = 8,
    parameter int                T_MRD            = 2,
    parameter int                REFRESH_INTERVAL = 780,
    parameter logic [ADDR_W-1:0] MODE_REG         = 13'h020
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [CMD_W-1:0]  cmd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ready_o
);

    localparam int CW = 16;

    sdram_state_e      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     rcnt_q, rcnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= CW'(INIT_CYCLES);
            rcnt_q  <= '0;
            cmd_q   <= CMD_INHIBIT;
            addr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
        end
    end

    // Each wait state runs for cnt+1 cycles; rcnt is zero on the cycle the
    // interval reference (first IDLE or a REFRESH) is on the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = '0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_PRE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_PRE: begin
                state_d = ST_PRE_WAIT;
                cnt_d   = CW'(T_RP - 1);
            end
            ST_PRE_WAIT: begin
                if (cnt_q == '0) state_d = ST_REF1;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_REF1: begin
                state_d = ST_REF1_WAIT;
                cnt_d   = CW'(T_RFC - 1);
            end
            ST_REF1_WAIT: begin
                if (cnt_q == '0) state_d = ST_REF2;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_REF2: begin
                state_d = ST_REF2_WAIT;
                cnt_d   = CW'(T_RFC - 1);
            end
            ST_REF2_WAIT: begin
                if (cnt_q == '0) state_d = ST_MRS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_MRS: begin
                state_d = ST_MRS_WAIT;
                cnt_d   = CW'(T_MRD - 1);
            end
            ST_MRS_WAIT: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_IDLE: begin
                if (rcnt_q == CW'(REFRESH_INTERVAL - 1)) state_d = ST_AREF;
                else                                     rcnt_d  = rcnt_q + 1'b1;
            end
            ST_AREF: begin
                state_d = ST_AREF_WAIT;
                cnt_d   = CW'(T_RFC - 1);
                rcnt_d  = rcnt_q + 1'b1;
            end
            ST_AREF_WAIT: begin
                rcnt_d = rcnt_q + 1'b1;
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Decoding the next state keeps the registered command aligned with state_q.
    always_comb begin
        cmd_d   = CMD_NOP;
        addr_d  = '0;
        ready_d = 1'b0;
        case (state_d)
            ST_PRE: begin
                cmd_d  = CMD_PRECHARGE;
                addr_d = ADDR_PRECHARGE_ALL;
            end
            ST_REF1, ST_REF2: cmd_d = CMD_REFRESH;
            ST_MRS: begin
                cmd_d  = CMD_LOAD_MODE;
                addr_d = MODE_REG;
            end
            ST_IDLE, ST_AREF_WAIT: ready_d = 1'b1;
            ST_AREF: begin
                cmd_d   = CMD_REFRESH;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_o   = cmd_q;
    assign addr_o  = addr_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/riscv_top.sv
// Bring-up top level: VGA timing with a test pattern, SDRAM init/refresh,
// LED status and idle levels on the unused peripheral pins.
module riscv_top
    import riscv_top_pkg::*;
#(
    parameter int                H_ACTIVE         = 640,
    parameter int                H_FP             = 16,
    parameter int                H_SYNC           = 96,
    parameter int                H_BP             = 48,
    parameter int                V_ACTIVE         = 480,
    parameter int                V_FP             = 10,
    parameter int                V_SYNC           = 2,
    parameter int                V_BP             = 33,
    parameter int                INIT_CYCLES      = 10000,
    parameter int                T_RP             = 3,
    parameter int                T_RFC            = 8,
    parameter int                T_MRD            = 2,
    parameter int                REFRESH_INTERVAL = 780,
    parameter logic [ADDR_W-1:0] MODE_REG         = 13'h020
) (
    input  logic              CLK_CPU,
    input  logic              RESET,
    input  logic              RX,
    output logic              TX,
    output logic [7:0]        LED,
    input  logic              SD_DO,
    output logic              SD_DI,
    output logic              SD_CK,
    output logic              SD_nCS,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC,
    output logic              VGA_BLANK,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    input  logic              PS2CLKA,
    input  logic              PS2DATA,
    input  logic              PS2CLKB,
    input  logic              PS2DATB,
    output logic              SDRAM_nCS,
    output logic              SDRAM_nRAS,
    output logic              SDRAM_nCAS,
    output logic              SDRAM_nWE,
    output logic [1:0]        SDRAM_BA,
    output logic [ADDR_W-1:0] SDRAM_ADDR,
    inout  wire  [15:0]       SDRAM_DATA,
    output logic              SDRAM_DQML,
    output logic              SDRAM_DQMH
);

    localparam int CW = 12;
    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic [6:0]    frame_q, frame_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          active;

    logic [CMD_W-1:0]  sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_ready;
    logic              unused_inputs;

    always_ff @(posedge CLK_CPU or negedge RESET) begin
        if (!RESET) begin
            hcount_q <= '0;
            vcount_q <= '0;
            frame_q  <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            blank_q  <= 1'b1;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            frame_q  <= frame_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    // Video outputs are decoded from the current counters, so they trail them by one clock.
    always_comb begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
        frame_d  = frame_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = vcount_q + 1'b1;
            if (vcount_q == V_LAST) begin
                vcount_d = '0;
                frame_d  = frame_q + 1'b1;
            end
        end

        active  = (hcount_q < CW'(H_ACTIVE)) && (vcount_q < CW'(V_ACTIVE));
        hsync_d = !((hcount_q >= H_SYNC_S) && (hcount_q < H_SYNC_E));
        vsync_d = !((vcount_q >= V_SYNC_S) && (vcount_q < V_SYNC_E));
        blank_d = !active;
        r_d     = active ? hcount_q[6:3] : 4'h0;
        g_d     = active ? vcount_q[6:3] : 4'h0;
        b_d     = active ? (hcount_q[9:6] ^ vcount_q[9:6]) : 4'h0;
    end

    riscv_top_sdram_init #(
        .INIT_CYCLES      (INIT_CYCLES),
        .T_RP             (T_RP),
        .T_RFC            (T_RFC),
        .T_MRD            (T_MRD),
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MODE_REG         (MODE_REG)
    ) u_sdram_init (
        .clk     (CLK_CPU),
        .rst_n   (RESET),
        .cmd_o   (sdram_cmd),
        .addr_o  (sdram_addr),
        .ready_o (sdram_ready)
    );

    assign VGA_HSYNC = hsync_q;
    assign VGA_VSYNC = vsync_q;
    assign VGA_BLANK = blank_q;
    assign VGA_R     = r_q;
    assign VGA_G     = g_q;
    assign VGA_B     = b_q;
    assign LED       = {sdram_ready, frame_q};

    assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = sdram_cmd;
    assign SDRAM_ADDR = sdram_addr;
    assign SDRAM_BA   = 2'b00;
    assign SDRAM_DQML = 1'b1;
    assign SDRAM_DQMH = 1'b1;
    assign SDRAM_DATA = 'z;

    // No core yet: peripheral pins sit at their idle levels.
    assign TX     = 1'b1;
    assign SD_nCS = 1'b1;
    assign SD_CK  = 1'b0;
    assign SD_DI  = 1'b1;

    assign unused_inputs = ^{RX, SD_DO, PS2CLKA, PS2DATA, PS2CLKB, PS2DATB};

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: a small-VGA instance and a medium-VGA instance checked
// every clock against a cycle-index model of the timing and SDRAM sequence.
module tb_riscv_top;

    localparam int INIT = 20;
    localparam int RINT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx, sd_do, ps2ca, ps2da, ps2cb, ps2db;

    logic        tx0, sd_di0, sd_ck0, sd_ncs0, hs0, vs0, bl0;
    logic [7:0]  led0;
    logic [3:0]  r0, g0, b0;
    logic        ncs0, nras0, ncas0, nwe0, dqml0, dqmh0;
    logic [1:0]  ba0;
    logic [12:0] addr0;
    wire  [15:0] data0;

    logic        tx1, sd_di1, sd_ck1, sd_ncs1, hs1, vs1, bl1;
    logic [7:0]  led1;
    logic [3:0]  r1, g1, b1;
    logic        ncs1, nras1, ncas1, nwe1, dqml1, dqmh1;
    logic [1:0]  ba1;
    logic [12:0] addr1;
    wire  [15:0] data1;

    int total = 0;
    int bad = 0;
    int k = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    riscv_top #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .INIT_CYCLES(INIT), .REFRESH_INTERVAL(RINT)
    ) dut (
        .CLK_CPU(clk), .RESET(rst_n), .RX(rx), .TX(tx0), .LED(led0),
        .SD_DO(sd_do), .SD_DI(sd_di0), .SD_CK(sd_ck0), .SD_nCS(sd_ncs0),
        .VGA_HSYNC(hs0), .VGA_VSYNC(vs0), .VGA_BLANK(bl0),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
        .PS2CLKA(ps2ca), .PS2DATA(ps2da), .PS2CLKB(ps2cb), .PS2DATB(ps2db),
        .SDRAM_nCS(ncs0), .SDRAM_nRAS(nras0), .SDRAM_nCAS(ncas0), .SDRAM_nWE(nwe0),
        .SDRAM_BA(ba0), .SDRAM_ADDR(addr0), .SDRAM_DATA(data0),
        .SDRAM_DQML(dqml0), .SDRAM_DQMH(dqmh0)
    );

    riscv_top #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(72), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .INIT_CYCLES(INIT), .REFRESH_INTERVAL(RINT)
    ) dut_wide (
        .CLK_CPU(clk), .RESET(rst_n), .RX(rx), .TX(tx1), .LED(led1),
        .SD_DO(sd_do), .SD_DI(sd_di1), .SD_CK(sd_ck1), .SD_nCS(sd_ncs1),
        .VGA_HSYNC(hs1), .VGA_VSYNC(vs1), .VGA_BLANK(bl1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .PS2CLKA(ps2ca), .PS2DATA(ps2da), .PS2CLKB(ps2cb), .PS2DATB(ps2db),
        .SDRAM_nCS(ncs1), .SDRAM_nRAS(nras1), .SDRAM_nCAS(ncas1), .SDRAM_nWE(nwe1),
        .SDRAM_BA(ba1), .SDRAM_ADDR(addr1), .SDRAM_DATA(data1),
        .SDRAM_DQML(dqml1), .SDRAM_DQMH(dqmh1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic push_n(input logic [3:0] cmd, input logic [12:0] addr, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({cmd, addr});
    endtask

    // Power-up command list, one entry per clock after reset release.
    task automatic build_init();
        exp_q.delete();
        push_n(4'b0111, 13'h0, INIT);
        push_n(4'b0010, 13'h0400, 1);
        push_n(4'b0111, 13'h0, 3);
        push_n(4'b0001, 13'h0, 1);
        push_n(4'b0111, 13'h0, 8);
        push_n(4'b0001, 13'h0, 1);
        push_n(4'b0111, 13'h0, 8);
        push_n(4'b0000, 13'h020, 1);
        push_n(4'b0111, 13'h0, 2);
    endtask

    task automatic check_vga(input string tag, input int ha, input int hf, input int hsw, input int hb,
                             input int va, input int vf, input int vsw, input int vb,
                             input logic hs_o, input logic vs_o, input logic bl_o,
                             input logic [3:0] r_o, input logic [3:0] g_o, input logic [3:0] b_o,
                             input logic [6:0] frame_o);
        int ht, vt, p, h, v;
        bit act;
        logic [31:0] hv, vv;
        logic [3:0] er, eg, eb;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (k == 0) begin
            chk({tag, "_hsync_rst"}, hs_o, 1);
            chk({tag, "_vsync_rst"}, vs_o, 1);
            chk({tag, "_blank_rst"}, bl_o, 1);
            chk({tag, "_rgb_rst"}, {r_o, g_o, b_o}, 0);
            chk({tag, "_frame_rst"}, frame_o, 0);
        end else begin
            p = (k - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
            hv = h;
            vv = v;
            act = (h < ha) && (v < va);
            er = act ? hv[6:3] : 4'h0;
            eg = act ? vv[6:3] : 4'h0;
            eb = act ? (hv[9:6] ^ vv[9:6]) : 4'h0;
            chk({tag, "_hsync"}, hs_o, !((h >= ha + hf) && (h < ha + hf + hsw)));
            chk({tag, "_vsync"}, vs_o, !((v >= va + vf) && (v < va + vf + vsw)));
            chk({tag, "_blank"}, bl_o, !act);
            chk({tag, "_rgb"}, {r_o, g_o, b_o}, {er, eg, eb});
            chk({tag, "_frame"}, frame_o, (k / (ht * vt)) % 128);
        end
    endtask

    task automatic check_all();
        logic [3:0]  ecmd;
        logic [12:0] eaddr;
        logic        erdy;
        int          j;
        if (k == 0) begin
            ecmd = 4'b1111; eaddr = '0; erdy = 1'b0;
        end else if (k <= exp_q.size()) begin
            ecmd = exp_q[k-1][16:13]; eaddr = exp_q[k-1][12:0]; erdy = 1'b0;
        end else begin
            j = k - exp_q.size() - 1;
            ecmd = (j > 0 && (j % RINT) == 0) ? 4'b0001 : 4'b0111;
            eaddr = '0;
            erdy = 1'b1;
        end
        chk("sdram_cmd", {ncs0, nras0, ncas0, nwe0}, ecmd);
        chk("sdram_addr", addr0, eaddr);
        chk("led_ready", led0[7], erdy);
        chk("wide_cmd", {ncs1, nras1, ncas1, nwe1}, ecmd);
        chk("wide_ready", led1[7], erdy);
        chk("sdram_static", {ba0, dqml0, dqmh0}, 4'b0011);
        chk("pins_idle", {tx0, sd_ncs0, sd_ck0, sd_di0}, 4'b1101);
        check_vga("vga", 8, 2, 2, 2, 4, 1, 1, 1, hs0, vs0, bl0, r0, g0, b0, led0[6:0]);
        check_vga("wvga", 80, 4, 8, 4, 72, 2, 2, 2, hs1, vs1, bl1, r1, g1, b1, led1[6:0]);
    endtask

    task automatic step(input bit inc);
        @(posedge clk);
        #1;
        if (inc) k++;
        {rx, sd_do, ps2ca, ps2da, ps2cb, ps2db} = 6'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            check_all();
        end
    endtask

    initial begin
        int n;
        build_init();
        {rx, sd_do, ps2ca, ps2da, ps2cb, ps2db} = 6'($urandom);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check_all();
        end

        // Full sequence, refresh cadence and past the 127->0 frame wrap (128*98 clocks).
        rst_n = 1'b1;
        run(12700);

        // Reset from idle, then again from inside the REF1 wait.
        rst_n = 1'b0;
        k = 0;
        #1;
        check_all();
        step(1'b0);
        check_all();
        rst_n = 1'b1;
        n = $urandom_range(26, 33);
        run(n);
        rst_n = 1'b0;
        k = 0;
        #1;
        check_all();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            step(1'b0);
            check_all();
        end
        rst_n = 1'b1;
        run(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_top.md
Name: riscv_top

Overview:
- Single-clock bring-up shell of the RISC-V SoC; the top-level that board/sim wrappers instantiate.
- This revision carries no CPU core. It provides:
  - a VGA timing generator with a test pattern,
  - an SDRAM power-up initialisation and auto-refresh controller,
  - an LED status register,
  - safe idle levels on UART, SPI/SD and PS/2 pins.
- Keeps the board pinout and SDRAM alive so a core can be dropped in later.

Parameters:
- H_ACTIVE 640; H_FP 16; H_SYNC 96; H_BP 48: horizontal timing in clocks.
- V_ACTIVE 480; V_FP 10; V_SYNC 2; V_BP 33: vertical timing in lines.
- INIT_CYCLES 10000: SDRAM power-up NOP wait.
- T_RP 3; T_RFC 8; T_MRD 2: SDRAM wait cycles after PRECHARGE, REFRESH and MRS respectively.
- REFRESH_INTERVAL 780: clocks between periodic refreshes.
- MODE_REG 13'h020: mode word (CAS 2, burst length 1, sequential).

Ports:
- CLK_CPU in 1: sole clock.
- RESET in 1: asynchronous active-low reset.
- RX in 1: UART receive (unused).
- TX out 1: UART transmit.
- LED out 8: status.
- SD_DO in 1: SPI data in (unused).
- SD_DI out 1; SD_CK out 1; SD_nCS out 1: SPI outputs.
- VGA_HSYNC out 1; VGA_VSYNC out 1: syncs, active-low.
- VGA_BLANK out 1: 1 outside the active area.
- VGA_R out 4; VGA_G out 4; VGA_B out 4: colour.
- PS2CLKA in 1; PS2DATA in 1; PS2CLKB in 1; PS2DATB in 1: unused.
- SDRAM_nCS out 1; SDRAM_nRAS out 1; SDRAM_nCAS out 1; SDRAM_nWE out 1: SDRAM command.
- SDRAM_BA out 2; SDRAM_ADDR out 13: bank and address.
- SDRAM_DATA inout 16: data bus.
- SDRAM_DQML out 1; SDRAM_DQMH out 1: byte masks.

Behaviour:
- Clocking/reset: one clock, CLK_CPU; reset is asynchronous, active-low, on RESET. All outputs are registered.
- Constant outputs:
  - TX=1, SD_nCS=1, SD_CK=0, SD_DI=1.
  - SDRAM_DATA always high-Z; SDRAM_BA=0; DQML=DQMH=1.
- Reset values:
  - hcount=vcount=0, frame count 0.
  - HSYNC=VSYNC=1, BLANK=1, RGB=0, LED=0.
  - SDRAM command INHIBIT ({nCS,nRAS,nCAS,nWE}=1111), ADDR=0.
- VGA counters:
  - hcount wraps 0..HT-1, where HT=sum of the four H parameters; vcount increments on hcount wrap and wraps 0..VT-1.
  - Active area: hcount<H_ACTIVE and vcount<V_ACTIVE.
  - HSYNC low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VSYNC low likewise on vcount.
  - Outputs lag the counters by exactly 1 clock, all mutually aligned.
  - Pattern, forced to 0 when blanked: R=hcount[6:3]; G=vcount[6:3]; B=hcount[9:6]^vcount[9:6].
  - Frame counter increments when hcount and vcount both wrap to 0 simultaneously.
- LED:
  - LED[7] = sdram_ready.
  - LED[6:0] = frame count[6:0], wrapping at 128.
- SDRAM FSM (command encoding {nCS,nRAS,nCAS,nWE}):
  - Encodings: NOP 0111, PRECHARGE 0010, REFRESH 0001, LOAD_MODE 0000.
  - Sequence:
    - WAIT: INIT_CYCLES NOPs.
    - PRE: one PRECHARGE with ADDR[10]=1, then T_RP NOPs.
    - REF1: one REFRESH, then T_RFC NOPs.
    - REF2: one REFRESH, then T_RFC NOPs.
    - MRS: one LOAD_MODE with ADDR=MODE_REG, then T_MRD NOPs.
    - IDLE: sdram_ready=1, NOPs issued.
  - Refresh counter starts on entering IDLE. Every REFRESH_INTERVAL clocks it issues one REFRESH, then T_RFC NOPs, then returns to IDLE; sdram_ready stays 1.
  - Interval is measured command-to-command.
  - Each command is asserted for exactly one clock.
  - ADDR=0 except during PRECHARGE and LOAD_MODE.
- Reset asserted mid-sequence: immediate INHIBIT, ready=0, and a full restart from WAIT on release.

Decomposition:
- Package riscv_top_pkg: SDRAM command localparams (CMD_INHIBIT, CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE) and the FSM state enum.
- One sub-module, riscv_top_sdram_init: init/refresh FSM, outputs command/ADDR/ready.
- VGA timing and pattern stay inline.

Test Plan (INIT_CYCLES=20, REFRESH_INTERVAL=50, small VGA: H 8/2/2/2, V 4/1/1/1):
- Reset held low -> command 1111, LED=0, BLANK=1, HSYNC=VSYNC=1, TX=1, SD_nCS=1.
- Release reset -> 20 NOPs; PRECHARGE with ADDR[10]=1; 3 NOPs; REFRESH; 8 NOPs; REFRESH; 8 NOPs; LOAD_MODE with ADDR=13'h020; 2 NOPs; LED[7]=1.
- Idle running -> REFRESH pulses exactly 50 clocks apart, each one clock wide, LED[7] held at 1.
- VGA -> HSYNC low for 2 clocks every 14 clocks, starting 10 clocks after line start (+1 latency); VSYNC low 1 line per 7 lines; RGB=0 whenever BLANK=1.
- Frames -> LED[6:0] increments once per 98 clocks and wraps 127->0.
- Reset pulsed low during the REF1 wait -> INHIBIT immediately; after release the sequence restarts with 20 NOPs and LED reset to 0.
